// File: rtl/top_level_pkg.sv
// Shared definitions for the LFSR message-encryption engine.
//   - state_t     : control FSM states
//   - ADDR_*      : fixed parameter locations in the data memory
//   - OUT_BASE    : first byte of the encrypted output area
//   - FRAME_LEN   : output frame length in bytes
//   - lfsr_next() : one LFSR step (result is 7 bits wide, bit 7 cleared)
package top_level_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_PRE,
    ST_LD_TAP,
    ST_LD_SEED,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [7:0] ADDR_PRE  = 8'd61;
  localparam logic [7:0] ADDR_TAP  = 8'd62;
  localparam logic [7:0] ADDR_SEED = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam int         FRAME_LEN = 64;

  // Shift left by one, dropping bits 7:6, and insert the tap parity at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
    return {1'b0, cur[5:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/top_level_if.sv
// Start/done handshake bundle for the encryption engine.
//   req : start request, active-low (driven by the requester)
//   ack : done flag (driven by the engine)
interface top_level_if;
  logic req;
  logic ack;

  modport master (output req, input  ack);
  modport slave  (input  req, output ack);
endinterface

// File: rtl/top_level_data_mem.sv
// 256x8 data memory with a single address port.
//   clk     : write clock
//   wr_en   : synchronous write enable
//   addr    : shared read/write address
//   wr_data : write data
//   rd_data : combinational read data
// The array is intentionally never reset; contents survive engine resets.
module data_mem (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data
);

  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (wr_en) core[addr] <= wr_data;
  end

  assign rd_data = core[addr];

endmodule

// File: rtl/top_level.sv
// LFSR message-encryption engine.
// On a low req it loads preamble length, tap mask and seed from memory, then
// for each of 64 frame positions reads one (space-padded) message byte and
// writes it XORed with the LFSR state to the output area. ack rises when the
// frame is complete and stays high until req returns high.
//   clk  : system clock
//   init : asynchronous active-low reset
//   req  : start request, active-low
//   ack  : registered done flag
module top_level
  import top_level_pkg::*;
(
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  state_t     r_state;
  logic [7:0] r_pre;
  logic [7:0] r_taps;
  logic [7:0] r_lfsr;
  logic [7:0] r_ch;
  logic [5:0] r_i;
  logic       r_ack;

  logic [7:0] w_addr;
  logic [7:0] w_rd_data;
  logic [7:0] w_wr_data;
  logic       w_wr_en;
  logic [7:0] w_i8;
  logic       w_in_msg;

  assign w_i8      = {2'b00, r_i};
  // Positions before the preamble end are padding (offset space = 0).
  assign w_in_msg  = (w_i8 >= r_pre);
  assign w_wr_data = (r_ch ^ r_lfsr) & 8'h7F;

  // Single memory port: the FSM state selects what the address means.
  always_comb begin
    w_addr  = 8'd0;
    w_wr_en = 1'b0;
    case (r_state)
      ST_LD_PRE:  w_addr = ADDR_PRE;
      ST_LD_TAP:  w_addr = ADDR_TAP;
      ST_LD_SEED: w_addr = ADDR_SEED;
      ST_RD:      w_addr = w_i8 - r_pre;
      ST_WR: begin
        w_addr  = OUT_BASE + w_i8;
        w_wr_en = 1'b1;
      end
      default:    w_addr = 8'd0;
    endcase
  end

  data_mem DM (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .addr    (w_addr),
    .wr_data (w_wr_data),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_i     <= '0;
      r_lfsr  <= '0;
      r_pre   <= '0;
      r_taps  <= '0;
      r_ch    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (!req) r_state <= ST_LD_PRE;
        end
        ST_LD_PRE: begin
          r_pre   <= w_rd_data;
          r_i     <= '0;
          r_state <= ST_LD_TAP;
        end
        ST_LD_TAP: begin
          r_taps  <= w_rd_data;
          r_i     <= '0;
          r_state <= ST_LD_SEED;
        end
        ST_LD_SEED: begin
          r_lfsr  <= w_rd_data;  // full 8-bit seed; bit 7 drops out after one step
          r_i     <= '0;
          r_state <= ST_RD;
        end
        ST_RD: begin
          r_ch    <= w_in_msg ? w_rd_data : 8'd0;
          r_state <= ST_WR;
        end
        ST_WR: begin
          r_lfsr <= lfsr_next(r_lfsr, r_taps);
          r_i    <= r_i + 6'd1;
          if (r_i == 6'(FRAME_LEN - 1)) begin
            r_state <= ST_DONE;
            r_ack   <= 1'b1;
          end else begin
            r_state <= ST_RD;
          end
        end
        ST_DONE: begin
          if (req) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ack = r_ack;

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;
  import top_level_pkg::*;

  logic clk  = 1'b0;
  logic init = 1'b0;
  top_level_if bus();

  always #5 clk = ~clk;

  top_level dut (
    .clk  (clk),
    .init (init),
    .req  (bus.req),
    .ack  (bus.ack)
  );

  typedef struct {
    logic [63:0][7:0] exp;
    int               ack_cyc;
  } exp_t;

  exp_t       sbq[$];
  int         cyc   = 0;
  int         npass = 0;
  int         ntot  = 0;
  logic       prev_ack = 1'b0;
  logic [7:0] msg [0:53];
  logic [7:0] tap_list [0:8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: padded character XOR LFSR, computed straight from the rules.
  function automatic logic [63:0][7:0] model(input int pre, input int taps, input int seed);
    logic [63:0][7:0] o;
    int L, p;
    L = seed;
    for (int i = 0; i < 64; i++) begin
      p    = (i < pre) ? 0 : int'(msg[i - pre]);
      o[i] = 8'((p ^ L) & 'h7F);
      L    = ((L & 'h3F) << 1) | ($countones(L & taps) & 1);
    end
    return o;
  endfunction

  task automatic preload(input int pre, input int taps, input int seed);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] v;
      if (k < 54)          v = msg[k];
      else if (k == 61)    v = 8'(pre);
      else if (k == 62)    v = 8'(taps);
      else if (k == 63)    v = 8'(seed);
      else if (k >= 64 && k < 128) v = 8'hEE;  // marker no valid output can hold
      else                 v = 8'h00;
      dut.DM.core[k] <= v;
    end
  endtask

  task automatic push_exp(input int pre, input int taps, input int seed);
    exp_t e;
    e.exp     = model(pre, taps, seed);
    e.ack_cyc = cyc + 132;
    sbq.push_back(e);
  endtask

  // Wait for ack, hold req low in DONE, then release and watch ack drop.
  task automatic finish_run(input string tag);
    int nwr;
    for (int t = 0; t < 300 && !bus.ack; t++) @(negedge clk);
    if (!bus.ack) check({tag, "_ack_timeout"}, 0, 1);
    nwr = 0;
    repeat (10) begin
      @(negedge clk);
      if (dut.DM.wr_en) nwr++;
    end
    check({tag, "_ack_held"}, int'(bus.ack), 1);
    check({tag, "_no_wr_done"}, nwr, 0);
    bus.req = 1'b1;
    @(negedge clk);
    check({tag, "_ack_drop"}, int'(bus.ack), 0);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int pre, input int taps, input int seed);
    preload(pre, taps, seed);
    @(negedge clk);
    push_exp(pre, taps, seed);
    bus.req = 1'b0;
    finish_run(tag);
  endtask

  task automatic load_string(input string s);
    for (int k = 0; k < 54; k++)
      msg[k] = (k < s.len()) ? 8'(s[k] - 8'h20) : 8'h00;
  endtask

  // Scoreboard monitor: on every ack rising edge, score the output frame.
  always @(negedge clk) begin
    prev_ack <= bus.ack;
    if (bus.ack && !prev_ack) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ack_latency", cyc, e.ack_cyc);
        for (int k = 0; k < 64; k++)
          check($sformatf("out[%0d]", k), int'(dut.DM.core[64 + k]), int'(e.exp[k]));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] gold [0:7];
    string      watson;
    int         pre, taps, seed;
    gold     = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};
    tap_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
    watson   = "Mr. Watson, come here. I want to see you.";

    bus.req = 1'b1;
    init    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",   int'(bus.ack), 0);
    check("rst_state", int'(dut.r_state), int'(ST_IDLE));
    check("rst_lfsr",  int'(dut.r_lfsr), 0);
    check("rst_i",     int'(dut.r_i), 0);
    init = 1'b1;
    @(negedge clk);

    // Directed: single character "M"
    for (int k = 0; k < 54; k++) msg[k] = 8'h00;
    msg[0] = 8'h2D;
    run("m", 10, 'h60, 'h01);
    for (int k = 0; k < 8; k++)
      check($sformatf("gold[%0d]", k), int'(dut.DM.core[64 + k]), int'(gold[k]));
    check("gold[74]", int'(dut.DM.core[74]), 'h35);

    // Watson string across all tap patterns
    load_string(watson);
    for (int t = 0; t < 9; t++) begin
      pre  = $urandom_range(10, 26);
      seed = $urandom_range(0, 255);
      run($sformatf("w%0d", t), pre, int'(tap_list[t]), seed);
    end

    // Zero seed, max preamble, full-length message: truncated plaintext
    for (int k = 0; k < 54; k++) msg[k] = 8'($urandom_range(0, 'h5F));
    run("z", 26, int'(tap_list[$urandom_range(0, 8)]), 0);
    for (int k = 0; k < 38; k++)
      check($sformatf("trunc[%0d]", k), int'(dut.DM.core[90 + k]), int'(msg[k]));
    check("trunc_pad", int'(dut.DM.core[89]), 0);

    // Seed with bit 7 set
    load_string(watson);
    run("ff", 15, 'h60, 'hFF);

    // Reset mid-run, then full rerun started by reset release with req low
    pre  = $urandom_range(10, 26);
    taps = int'(tap_list[$urandom_range(0, 8)]);
    seed = $urandom_range(1, 255);
    preload(pre, taps, seed);
    @(negedge clk);
    bus.req = 1'b0;
    repeat (49) @(negedge clk);
    init = 1'b0;
    #1;
    check("mid_rst_ack",   int'(bus.ack), 0);
    check("mid_rst_state", int'(dut.r_state), int'(ST_IDLE));
    check("mid_rst_i",     int'(dut.r_i), 0);
    check("mid_rst_lfsr",  int'(dut.r_lfsr), 0);
    preload(pre, taps, seed);
    @(negedge clk);
    @(negedge clk);
    push_exp(pre, taps, seed);
    init = 1'b1;
    finish_run("rerun");

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/top_level.md
# top_level

Hard-wired LFSR message-encryption engine with its own 256-byte data memory. On request it reads a message, a preamble length, an LFSR tap pattern and an LFSR seed from memory. It writes a 64-byte encrypted, space-padded message back to memory and raises a done flag. It is the top of the design; the data memory is preloaded and read back hierarchically as `DM.core`.

## Interface
- No parameters. Memory depth is fixed at 256×8; message frame length is fixed at 64.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `init`  input  1  asynchronous, active-low reset.
- `req`  input  1  start request, active-low. While high, the engine is held in IDLE. Going low launches one run.
- `ack`  output  1  done flag; high when the run has completed.

## Operation
Memory map:
- `DM.core[0..53]`: message characters, each already offset by −0x20. Unused bytes are 0.
- `DM.core[61]`: preamble length `pre` (10..26).
- `DM.core[62]`: tap mask `taps` (7-bit, bit 7 = 0).
- `DM.core[63]`: LFSR seed.
- `DM.core[64..127]`: output area.

Algorithm for i = 0..63:
- Padded character: `p[i]` = 0 if i < pre, else `DM.core[i−pre]`. The message is truncated at frame end; 0 is an offset space.
- LFSR: `L[0]` = seed (8-bit, used as-is). `L[i+1]` = {`L[i]`[5:0], ^(`L[i]` & taps)}, so it is 7 bits wide after the first step.
- Output: `DM.core[64+i]` = {1'b0, (`p[i]` ^ `L[i]`)[6:0]}. Bit 7 is always cleared.
- A zero seed is not corrected: the LFSR stays 0 and the output equals the padded input.

Control FSM states:
- IDLE: `ack` = 0. Moves to LD_PRE when `req` = 0.
- LD_PRE, LD_TAP, LD_SEED: one cycle each. Each latches `DM.core[61]`, `[62]`, `[63]` respectively and clears counter i to 0.
- RD: computes the read address `i−pre` when i ≥ pre and latches the byte into `ch`; otherwise latches 0.
- WR: writes `DM.core[64+i]`, advances the LFSR, and increments i. Goes to DONE if i was 63, else back to RD.
- DONE: `ack` = 1. Returns to IDLE when `req` = 1. Stays in DONE while `req` stays 0, so there is no auto-restart.

Reset behaviour:
- Reset (`init` = 0) forces IDLE, `ack` = 0, i = 0, LFSR = 0.
- Memory contents are not reset.
- Reset mid-run aborts the run; already-written output bytes remain.

## Timing
- Memory read is combinational (async); memory write is synchronous.
- There is a single address port, muxed by the FSM, so one read or one write per cycle.
- Latency from the first rising edge with `req` = 0 to `ack` = 1: 3 load cycles + 128 RD/WR cycles, so `ack` is high on cycle 132.
- `ack` is registered and glitch-free. It is high throughout DONE.
- `DM.core[64..127]` are stable and final when `ack` rises.
- `req` is sampled only in IDLE and DONE.

## Structure
- Shared package `top_level_pkg`:
  - FSM state enum.
  - Address constants: `ADDR_PRE` = 61, `ADDR_TAP` = 62, `ADDR_SEED` = 63, `OUT_BASE` = 64.
  - `FRAME_LEN` = 64.
- One sub-module `data_mem`, instantiated as `DM`:
  - Array `core[0:255]` of 8 bits.
  - Ports: `clk`, `wr_en`, `addr[7:0]`, `wr_data[7:0]`, `rd_data[7:0]` (async read).
  - No reset of the array.
- The FSM and datapath (LFSR, counter, `pre`/`taps`/`ch` registers) live in `top_level`.

## Test plan
- Seed 0x01, taps 0x60, pre 10, message "M" (0x2D at `core[0]`) -> `core[64..71]` = 01 02 04 08 10 20 41 03; `core[74]` = 0x35; `ack` high at cycle 132.
- String "Mr. Watson, come here. I want to see you.", all 9 tap patterns (60 48 78 72 6A 69 5C 7E 7B), random seed, pre 10..26 -> all 64 bytes match the algorithm; score 64/64.
- Seed 0x00, pre 26, 54-char message -> output = offset message bytes `core[0..37]` at `core[90..127]`, zeros before; message truncated.
- Seed 0xFF (bit 7 set) -> bit 7 of every output byte is 0 and `L[1]` is 7-bit.
- Assert `init` = 0 mid-run (cycle 50) -> `ack` = 0 immediately, FSM in IDLE. Release with `req` = 0 -> a full rerun completes and the output is correct.
- Hold `req` = 0 after DONE -> `ack` stays 1 and there are no further writes. `req` = 1 -> `ack` = 0 next cycle.
